// File: rtl/cnn_pkg.sv
// Shared constants, launch-state type and pixel placement helper for the CNN frame loader.
package cnn_pkg;

   localparam int unsigned IMG_DIM  = 8;
   localparam int unsigned IMG_BITS = IMG_DIM * IMG_DIM;
   localparam int unsigned CLASS_W  = 4;

   typedef enum logic [1:0] {
      L_IDLE,
      L_START,
      L_BUSY
   } launch_state_e;

   // Bit position of pixel (r,c) inside the packed image word.
   function automatic int unsigned pix_bit_index(input int unsigned r, input int unsigned c);
      return IMG_BITS - 1 - (IMG_DIM * r + c);
   endfunction

endpackage

// File: rtl/cnn_pixel_packer.sv
// Binarises accepted pixels and packs them row-major into a 64-bit frame with framing checks.
module cnn_pixel_packer
   import cnn_pkg::*;
#(
   parameter int unsigned PIX_W = 8
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [PIX_W-1:0]    pix_data_i,
   input  logic                pix_valid_i,
   input  logic                pix_sof_i,
   input  logic [PIX_W-1:0]    threshold_i,
   input  logic                clear_full_i,
   output logic                pix_ready_o,
   output logic                full_o,
   output logic [IMG_BITS-1:0] frame_o,
   output logic                frame_err_o
);

   localparam int unsigned CNT_W = $clog2(IMG_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IMG_BITS - 1);

   logic [CNT_W-1:0]    count_q, count_d;
   logic [IMG_BITS-1:0] sr_q, sr_d;
   logic                full_q, full_d;
   logic                err_q, err_d;
   logic                accept;
   logic                pix_bit;

   assign pix_ready_o = !rst_i && !full_q;
   assign accept      = pix_valid_i && pix_ready_o;
   assign pix_bit     = (pix_data_i >= threshold_i);

   always_comb begin
      count_d = count_q;
      sr_d    = sr_q;
      full_d  = full_q;
      err_d   = 1'b0;
      if (clear_full_i) begin
         full_d = 1'b0;
      end
      if (accept) begin
         if (pix_sof_i && (count_q != '0)) begin
            // Restart: stale bits shift out before the new frame can complete.
            err_d   = 1'b1;
            sr_d    = {sr_q[IMG_BITS-2:0], pix_bit};
            count_d = CNT_W'(1);
         end else if (!pix_sof_i && (count_q == '0)) begin
            err_d = 1'b1;
         end else begin
            sr_d    = {sr_q[IMG_BITS-2:0], pix_bit};
            count_d = count_q + CNT_W'(1);
            if (count_q == CNT_LAST) begin
               full_d = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
         sr_q    <= '0;
         full_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         sr_q    <= sr_d;
         full_q  <= full_d;
         err_q   <= err_d;
      end
   end

   assign full_o      = full_q;
   assign frame_o     = sr_q;
   assign frame_err_o = err_q;

endmodule

// File: rtl/cnn_frame_loader.sv
// Double-buffered frame feeder for the CNN: launch FSM, done edge detection and watchdog.
module cnn_frame_loader
   import cnn_pkg::*;
#(
   parameter int unsigned PIX_W       = 8,
   parameter int unsigned TIMEOUT_CYC = 4096
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [PIX_W-1:0]    pix_data_i,
   input  logic                pix_valid_i,
   input  logic                pix_sof_i,
   output logic                pix_ready_o,
   input  logic [PIX_W-1:0]    threshold_i,
   output logic [IMG_BITS-1:0] image_input_o,
   output logic                start_o,
   input  logic                done_i,
   input  logic [CLASS_W-1:0]  classification_i,
   output logic [CLASS_W-1:0]  res_class_o,
   output logic                res_valid_o,
   output logic                res_timeout_o,
   output logic                frame_err_o,
   output logic                busy_o
);

   localparam int unsigned WD_W = $clog2(TIMEOUT_CYC + 2);
   localparam logic [WD_W-1:0] WD_LIM = WD_W'(TIMEOUT_CYC);

   launch_state_e       state_q, state_d;
   logic [IMG_BITS-1:0] image_q, image_d;
   logic [WD_W-1:0]     wd_q, wd_d;
   logic [CLASS_W-1:0]  res_class_q, res_class_d;
   logic                res_valid_q, res_valid_d;
   logic                res_to_q, res_to_d;
   logic                done_q;
   logic                done_rise;
   logic                wd_expire;
   logic                full;
   logic                frame_err;
   logic [IMG_BITS-1:0] frame;

   // Full is held through L_START so the fill side stalls until the launch pulse has gone out.
   cnn_pixel_packer #(
      .PIX_W(PIX_W)
   ) u_packer (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .pix_data_i  (pix_data_i),
      .pix_valid_i (pix_valid_i),
      .pix_sof_i   (pix_sof_i),
      .threshold_i (threshold_i),
      .clear_full_i(state_q == L_START),
      .pix_ready_o (pix_ready_o),
      .full_o      (full),
      .frame_o     (frame),
      .frame_err_o (frame_err)
   );

   assign done_rise = done_i && !done_q;
   assign wd_expire = (TIMEOUT_CYC != 0) && ((wd_q + WD_W'(1)) == WD_LIM);

   always_comb begin
      state_d     = state_q;
      image_d     = image_q;
      wd_d        = wd_q;
      res_class_d = res_class_q;
      res_valid_d = 1'b0;
      res_to_d    = res_to_q;
      unique case (state_q)
         L_IDLE: begin
            if (full) begin
               image_d = frame;
               state_d = L_START;
            end
         end
         L_START: begin
            wd_d    = '0;
            state_d = L_BUSY;
         end
         L_BUSY: begin
            // A done edge wins over a coincident watchdog expiry.
            if (done_rise) begin
               res_class_d = classification_i;
               res_to_d    = 1'b0;
               res_valid_d = 1'b1;
               state_d     = L_IDLE;
            end else if (wd_expire) begin
               res_class_d = '0;
               res_to_d    = 1'b1;
               res_valid_d = 1'b1;
               state_d     = L_IDLE;
            end else if (wd_q != '1) begin
               wd_d = wd_q + WD_W'(1);
            end
         end
         default: state_d = L_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= L_IDLE;
         image_q     <= '0;
         wd_q        <= '0;
         res_class_q <= '0;
         res_valid_q <= 1'b0;
         res_to_q    <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         image_q     <= image_d;
         wd_q        <= wd_d;
         res_class_q <= res_class_d;
         res_valid_q <= res_valid_d;
         res_to_q    <= res_to_d;
         done_q      <= done_i;
      end
   end

   assign image_input_o = rst_i ? '0 : image_q;
   assign start_o       = !rst_i && (state_q == L_START);
   assign busy_o        = !rst_i && (state_q == L_BUSY);
   assign res_class_o   = rst_i ? '0 : res_class_q;
   assign res_valid_o   = !rst_i && res_valid_q;
   assign res_timeout_o = !rst_i && res_to_q;
   assign frame_err_o   = !rst_i && frame_err;

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Directed bench for cnn_frame_loader: packing, launch timing, framing errors, stale done, watchdog.
module tb_cnn_frame_loader;
   import cnn_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  pix_data = '0;
   logic        pix_valid = 1'b0;
   logic        pix_sof = 1'b0;
   logic [7:0]  threshold = 8'h80;
   logic        done = 1'b0;
   logic [3:0]  classification = '0;

   logic        pix_ready, start, res_valid, res_timeout, frame_err, busy;
   logic [63:0] image;
   logic [3:0]  res_class;

   logic        wd_pix_ready, wd_start, wd_res_valid, wd_res_timeout, wd_frame_err, wd_busy;
   logic [63:0] wd_image;
   logic [3:0]  wd_res_class;

   cnn_frame_loader #(
      .PIX_W      (8),
      .TIMEOUT_CYC(4096)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .pix_data_i      (pix_data),
      .pix_valid_i     (pix_valid),
      .pix_sof_i       (pix_sof),
      .pix_ready_o     (pix_ready),
      .threshold_i     (threshold),
      .image_input_o   (image),
      .start_o         (start),
      .done_i          (done),
      .classification_i(classification),
      .res_class_o     (res_class),
      .res_valid_o     (res_valid),
      .res_timeout_o   (res_timeout),
      .frame_err_o     (frame_err),
      .busy_o          (busy)
   );

   cnn_frame_loader #(
      .PIX_W      (8),
      .TIMEOUT_CYC(16)
   ) dut_wd (
      .clk_i           (clk),
      .rst_i           (rst),
      .pix_data_i      (pix_data),
      .pix_valid_i     (pix_valid),
      .pix_sof_i       (pix_sof),
      .pix_ready_o     (wd_pix_ready),
      .threshold_i     (threshold),
      .image_input_o   (wd_image),
      .start_o         (wd_start),
      .done_i          (done),
      .classification_i(classification),
      .res_class_o     (wd_res_class),
      .res_valid_o     (wd_res_valid),
      .res_timeout_o   (wd_res_timeout),
      .frame_err_o     (wd_frame_err),
      .busy_o          (wd_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int start_cnt = 0, last_start_cyc = -1;
   int res_cnt = 0, last_res_cyc = -1;
   int ferr_cnt = 0;
   logic [3:0] last_res_class = '0;
   logic       last_res_to = 1'b0;

   always @(negedge clk) begin
      if (start) begin
         start_cnt++;
         last_start_cyc = cyc;
      end
      if (res_valid) begin
         res_cnt++;
         last_res_cyc   = cyc;
         last_res_class = res_class;
         last_res_to    = res_timeout;
      end
      if (frame_err) ferr_cnt++;
   end

   int n_chk = 0, n_fail = 0;
   int acc_cyc = 0;
   logic [7:0] fr [64];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic fill_frame(input logic [7:0] v);
      for (int i = 0; i < 64; i++) fr[i] = v;
   endtask

   task automatic stream_pix(input logic [7:0] d, input logic sof);
      int guard;
      guard     = 0;
      pix_data  = d;
      pix_sof   = sof;
      pix_valid = 1'b1;
      while (!pix_ready && guard < 200) begin
         tick(1);
         guard++;
      end
      if (!pix_ready) check_eq("ready_wait", pix_ready, 1);
      acc_cyc = cyc;
      tick(1);
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic stream_frame();
      for (int i = 0; i < 64; i++) stream_pix(fr[i], i == 0);
   endtask

   task automatic wait_busy(input string tag);
      int guard;
      guard = 0;
      while (!busy && guard < 20) begin
         tick(1);
         guard++;
      end
      if (!busy) check_eq(tag, busy, 1);
   endtask

   task automatic pulse_done(input logic [3:0] c, output int d);
      classification = c;
      done           = 1'b1;
      d              = cyc;
      tick(1);
      done = 1'b0;
   endtask

   initial begin
      int n, d, r0, s0, e0, bc;

      // Reset state
      tick(3);
      check_eq("rst_outs", {pix_ready, start, busy, res_valid, res_timeout, frame_err, res_class}, 0);
      check_eq("rst_img", image, 0);
      rst = 1'b0;
      tick(1);
      check_eq("ready_after_rst", pix_ready, 1);

      // Single bright pixel at (7,0); launch timing
      fill_frame(8'h00);
      fr[56] = 8'hFF;
      s0 = start_cnt;
      stream_frame();
      n = acc_cyc;
      check_eq("t1_ready_n1", pix_ready, 0);
      check_eq("t1_start_n1", start, 0);
      tick(1);
      check_eq("t1_cyc_n2", cyc, n + 2);
      check_eq("t1_ready_n2", pix_ready, 0);
      check_eq("t1_start_n2", start, 1);
      tick(1);
      check_eq("t1_ready_n3", pix_ready, 1);
      check_eq("t1_start_n3", start, 0);
      check_eq("t1_busy", busy, 1);
      check_eq("t1_image", image, 64'h0000000000000080);
      check_eq("t1_start_cnt", start_cnt, s0 + 1);
      r0 = res_cnt;
      pulse_done(4'd3, d);
      tick(3);
      check_eq("t1_res_cnt", res_cnt, r0 + 1);
      check_eq("t1_res_cyc", last_res_cyc, d + 1);
      check_eq("t1_res_class", last_res_class, 3);

      // Alternating rows, class 5
      for (int i = 0; i < 64; i++) fr[i] = ((i / 8) % 2 == 1) ? 8'hFF : 8'h00;
      stream_frame();
      wait_busy("t2_wait_busy");
      check_eq("t2_image", image, 64'h00FF00FF00FF00FF);
      r0 = res_cnt;
      tick(2);
      pulse_done(4'd5, d);
      tick(4);
      check_eq("t2_res_cnt", res_cnt, r0 + 1);
      check_eq("t2_res_class", res_class, 5);
      check_eq("t2_res_to", last_res_to, 0);
      check_eq("t2_idle", busy, 0);

      // Threshold boundary: 0x7F below, 0x80 at level
      fill_frame(8'h00);
      fr[0] = 8'h7F;
      fr[1] = 8'h80;
      stream_frame();
      wait_busy("t3_wait_busy");
      check_eq("t3_image", image, 64'h4000000000000000);
      pulse_done(4'd1, d);
      tick(2);

      // SOF reasserted at count 10
      e0 = ferr_cnt;
      for (int i = 0; i < 10; i++) stream_pix(8'hFF, i == 0);
      for (int i = 0; i < 64; i++) fr[i] = ((i % 9) == 0) ? 8'hFF : 8'h00;
      stream_frame();
      tick(2);
      check_eq("t4_ferr_restart", ferr_cnt, e0 + 1);
      wait_busy("t4_wait_busy");
      check_eq("t4_image", image, 64'h8040201008040201);
      pulse_done(4'd2, d);
      tick(2);

      // Non-SOF pixel at count 0 is dropped
      e0 = ferr_cnt;
      stream_pix(8'hFF, 1'b0);
      tick(2);
      check_eq("t4_ferr_stray", ferr_cnt, e0 + 1);
      fill_frame(8'h00);
      fr[28] = 8'hFF;
      stream_frame();
      wait_busy("t4b_wait_busy");
      check_eq("t4b_image", image, 64'h0000000800000000);
      check_eq("t4b_ferr_none", ferr_cnt, e0 + 1);
      pulse_done(4'd2, d);
      tick(2);

      // Stale done high across launch; frame 2 fills while busy
      done = 1'b1;
      fill_frame(8'hFF);
      stream_frame();
      wait_busy("t5_wait_busy");
      r0 = res_cnt;
      for (int i = 0; i < 64; i++) fr[i] = ((i % 2) == 0) ? 8'hFF : 8'h00;
      stream_frame();
      tick(3);
      check_eq("t5_still_busy", busy, 1);
      check_eq("t5_no_result", res_cnt, r0);
      check_eq("t5_full_stall", pix_ready, 0);
      s0 = start_cnt;
      done = 1'b0;
      tick(1);
      done = 1'b1;
      d = cyc;
      tick(4);
      check_eq("t5_res_cyc", last_res_cyc, d + 1);
      check_eq("t5_start_cyc", last_start_cyc, d + 2);
      check_eq("t5_start_cnt", start_cnt, s0 + 1);
      check_eq("t5_image2", image, 64'hAAAAAAAAAAAAAAAA);
      check_eq("t5_busy2", busy, 1);
      done = 1'b0;
      tick(1);
      pulse_done(4'd4, d);
      tick(2);

      // Reset mid-fill
      for (int i = 0; i < 20; i++) stream_pix(8'hFF, i == 0);
      rst = 1'b1;
      tick(1);
      check_eq("rst2_outs", {pix_ready, start, busy, res_valid, res_timeout, frame_err, res_class}, 0);
      check_eq("rst2_img", image, 0);
      tick(1);
      rst = 1'b0;
      tick(1);
      e0 = ferr_cnt;
      fill_frame(8'h00);
      fr[7] = 8'hFF;
      stream_frame();
      wait_busy("t6_wait_busy");
      check_eq("t6_image", image, 64'h0100000000000000);
      check_eq("t6_ferr_none", ferr_cnt, e0);
      pulse_done(4'd7, d);
      tick(2);

      // Watchdog on the 16-cycle instance
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(1);
      fill_frame(8'h00);
      fr[0] = 8'hFF;
      stream_frame();
      bc = 0;
      while (!wd_busy && bc < 20) begin
         tick(1);
         bc++;
      end
      pulse_done(4'd9, d);
      tick(2);
      check_eq("wd_done_class", wd_res_class, 9);
      fill_frame(8'h00);
      fr[9] = 8'hFF;
      stream_frame();
      bc = 0;
      for (int i = 0; i < 100; i++) begin
         if (wd_res_valid) break;
         if (wd_busy) bc++;
         tick(1);
      end
      check_eq("wd_res_valid", wd_res_valid, 1);
      check_eq("wd_busy_cycles", bc, 16);
      check_eq("wd_res_to", wd_res_timeout, 1);
      check_eq("wd_res_class0", wd_res_class, 0);
      fill_frame(8'h00);
      fr[63] = 8'hFF;
      stream_frame();
      bc = 0;
      while (!wd_busy && bc < 20) begin
         tick(1);
         bc++;
      end
      check_eq("wd_relaunch_busy", wd_busy, 1);
      check_eq("wd_relaunch_image", wd_image, 64'h0000000000000001);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
